// File: rtl/fifo_input_control.sv
// -----------------------------------------------------------------------------
// fifo_input_control
// Write-side controller of the FIFO. It accepts producer writes, presents
// registered write strobes, slot pointers and data to the storage, tracks
// occupancy using the read side's pop strobe, and raises full, almost-full
// and overflow flags. Data value 0 marks an empty slot downstream, so a write
// of 0 is never forwarded to the storage.
//
// Handshake: write_en has no back-pressure. The producer watches full and
// overflow itself. A write is taken on the rising edge where write_en=1,
// data_in!=0, and the FIFO is not full (or read_pop frees a slot in that same
// cycle). The storage sees the accepted write one cycle later, while
// write_en_o=1.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   write_en     producer write request
//   data_in      producer data
//   read_pop     one-cycle pop strobe from the read-side controller
//   write_en_o   registered storage write strobe
//   wr_ptr       storage slot, valid while write_en_o=1
//   data_in_f    storage data, valid while write_en_o=1
//   count        occupancy, 0..DEPTH
//   full         count==DEPTH
//   almost_full  count>=AF_LEVEL
//   overflow     sticky: a write was rejected because the FIFO was full
//   zero_drop    one-cycle pulse: a write was rejected because data_in==0
//   state_dbg    current FSM state (0=EMPTY, 1=ACTIVE, 2=FULL)
// -----------------------------------------------------------------------------
module fifo_input_control #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 32,
  parameter int PTR_W    = 5,
  parameter int AF_LEVEL = 28
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read_pop,
  output logic              write_en_o,
  output logic [PTR_W-1:0]  wr_ptr,
  output logic [DATA_W-1:0] data_in_f,
  output logic [PTR_W:0]    count,
  output logic              full,
  output logic              almost_full,
  output logic              overflow,
  output logic              zero_drop,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    ACTIVE = 2'd1,
    FULL   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [PTR_W-1:0]    r_next_ptr;
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [DATA_W-1:0]   r_data;
  logic [PTR_W:0]      r_count;
  logic                r_wen;
  logic                r_full;
  logic                r_af;
  logic                r_ovf;
  logic                r_zdrop;

  logic                w_nonzero;
  logic                w_acc;
  logic                w_pop_ok;
  logic                w_ovf_set;
  logic [PTR_W:0]      w_count_next;

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] AF_C    = (PTR_W+1)'(AF_LEVEL);

  always_comb begin
    w_nonzero    = (data_in != '0);
    // A pop in the same cycle frees a slot, so a write at FULL can still go in.
    w_acc        = write_en & w_nonzero & ((r_state != FULL) | read_pop);
    w_pop_ok     = read_pop & (r_state != EMPTY);
    w_ovf_set    = write_en & w_nonzero & (r_state == FULL) & ~read_pop;
    w_count_next = r_count + (PTR_W+1)'(w_acc) - (PTR_W+1)'(w_pop_ok);

    w_state_next = ACTIVE;
    if (w_count_next == '0) begin
      w_state_next = EMPTY;
    end else if (w_count_next == DEPTH_C) begin
      w_state_next = FULL;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_next_ptr <= '0;
      r_wr_ptr   <= '0;
      r_data     <= '0;
      r_count    <= '0;
      r_wen      <= 1'b0;
      r_full     <= 1'b0;
      r_af       <= 1'b0;
      r_ovf      <= 1'b0;
      r_zdrop    <= 1'b0;
    end else begin
      r_wen   <= w_acc;
      r_count <= w_count_next;
      r_full  <= (w_count_next == DEPTH_C);
      r_af    <= (w_count_next >= AF_C);
      r_zdrop <= write_en & ~w_nonzero;
      if (w_acc) begin
        r_wr_ptr   <= r_next_ptr;
        r_data     <= data_in;
        // DEPTH is a power of two, so the natural wrap gives modulo DEPTH.
        r_next_ptr <= r_next_ptr + 1'b1;
        r_ovf      <= 1'b0;
      end else if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign write_en_o  = r_wen;
  assign wr_ptr      = r_wr_ptr;
  assign data_in_f   = r_data;
  assign count       = r_count;
  assign full        = r_full;
  assign almost_full = r_af;
  assign overflow    = r_ovf;
  assign zero_drop   = r_zdrop;
  assign state_dbg   = r_state;

endmodule

// File: tb/tb_fifo_input_control.sv
// -----------------------------------------------------------------------------
// tb_fifo_input_control
// Directed bench for fifo_input_control. Inputs change 1 time unit after the
// rising edge. Outputs are checked 1 time unit after the edge that registers
// the response.
// -----------------------------------------------------------------------------
module tb_fifo_input_control;

  logic       clk;
  logic       reset;
  logic       write_en;
  logic [7:0] data_in;
  logic       read_pop;
  logic       write_en_o;
  logic [4:0] wr_ptr;
  logic [7:0] data_in_f;
  logic [5:0] count;
  logic       full;
  logic       almost_full;
  logic       overflow;
  logic       zero_drop;
  logic [1:0] state_dbg;

  int checks;
  int failures;

  fifo_input_control dut (
    .clk         (clk),
    .reset       (reset),
    .write_en    (write_en),
    .data_in     (data_in),
    .read_pop    (read_pop),
    .write_en_o  (write_en_o),
    .wr_ptr      (wr_ptr),
    .data_in_f   (data_in_f),
    .count       (count),
    .full        (full),
    .almost_full (almost_full),
    .overflow    (overflow),
    .zero_drop   (zero_drop),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: apply inputs for one cycle, then settle after the edge
  task automatic step(input logic rst_n, input logic we, input logic [7:0] d,
                      input logic pop);
    reset    = rst_n;
    write_en = we;
    data_in  = d;
    read_pop = pop;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_wen"},  32'(write_en_o),  32'd0);
    chk({tag, "_ptr"},  32'(wr_ptr),      32'd0);
    chk({tag, "_data"}, 32'(data_in_f),   32'd0);
    chk({tag, "_cnt"},  32'(count),       32'd0);
    chk({tag, "_full"}, 32'(full),        32'd0);
    chk({tag, "_af"},   32'(almost_full), 32'd0);
    chk({tag, "_ovf"},  32'(overflow),    32'd0);
    chk({tag, "_zd"},   32'(zero_drop),   32'd0);
    chk({tag, "_st"},   32'(state_dbg),   32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    write_en = 1'b0;
    data_in  = 8'd0;
    read_pop = 1'b0;

    // 1. reset for two clocks, then a single write
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk_reset_state("rst");
    step(1'b1, 1'b1, 8'hA5, 1'b0);
    chk("w1_wen",  32'(write_en_o), 32'd1);
    chk("w1_ptr",  32'(wr_ptr),     32'd0);
    chk("w1_data", 32'(data_in_f),  32'hA5);
    chk("w1_cnt",  32'(count),      32'd1);
    chk("w1_st",   32'(state_dbg),  32'd1);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("idle_wen",  32'(write_en_o), 32'd0);
    chk("idle_ptr",  32'(wr_ptr),     32'd0);
    chk("idle_data", 32'(data_in_f),  32'hA5);
    chk("idle_cnt",  32'(count),      32'd1);

    // 2. fill from empty with 1..32
    step(1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 1; i <= 32; i++) begin
      step(1'b1, 1'b1, 8'(i), 1'b0);
      chk("fill_wen",  32'(write_en_o),  32'd1);
      chk("fill_ptr",  32'(wr_ptr),      32'(i - 1));
      chk("fill_data", 32'(data_in_f),   32'(i));
      chk("fill_cnt",  32'(count),       32'(i));
      chk("fill_af",   32'(almost_full), (i >= 28) ? 32'd1 : 32'd0);
      chk("fill_full", 32'(full),        (i == 32) ? 32'd1 : 32'd0);
    end
    chk("full_st", 32'(state_dbg), 32'd2);
    // 33rd write is rejected
    step(1'b1, 1'b1, 8'h55, 1'b0);
    chk("ovf_wen",  32'(write_en_o), 32'd0);
    chk("ovf_flag", 32'(overflow),   32'd1);
    chk("ovf_cnt",  32'(count),      32'd32);
    chk("ovf_ptr",  32'(wr_ptr),     32'd31);
    chk("ovf_data", 32'(data_in_f),  32'd32);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // 3. write with pop at FULL: accepted, pointer wraps
    step(1'b1, 1'b1, 8'h11, 1'b1);
    chk("wp_wen",  32'(write_en_o), 32'd1);
    chk("wp_ptr",  32'(wr_ptr),     32'd0);
    chk("wp_data", 32'(data_in_f),  32'h11);
    chk("wp_cnt",  32'(count),      32'd32);
    chk("wp_ovf",  32'(overflow),   32'd0);
    chk("wp_full", 32'(full),       32'd1);

    // 4. zero data is dropped
    step(1'b1, 1'b1, 8'h00, 1'b0);
    chk("zd_pulse", 32'(zero_drop),  32'd1);
    chk("zd_wen",   32'(write_en_o), 32'd0);
    chk("zd_cnt",   32'(count),      32'd32);
    chk("zd_ptr",   32'(wr_ptr),     32'd0);
    chk("zd_ovf",   32'(overflow),   32'd0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("zd_end", 32'(zero_drop), 32'd0);

    // 5. pop while empty, then write+pop at count 5
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    chk("pe_cnt", 32'(count),     32'd0);
    chk("pe_st",  32'(state_dbg), 32'd0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 8'(8'h40 + i), 1'b0);
    chk("c5_cnt", 32'(count),  32'd5);
    chk("c5_ptr", 32'(wr_ptr), 32'd4);
    step(1'b1, 1'b1, 8'h77, 1'b1);
    chk("c5wp_cnt", 32'(count),      32'd5);
    chk("c5wp_ptr", 32'(wr_ptr),     32'd5);
    chk("c5wp_wen", 32'(write_en_o), 32'd1);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    chk("pop_cnt", 32'(count),      32'd4);
    chk("pop_wen", 32'(write_en_o), 32'd0);

    // 6. reset mid-burst at count 17, with a write pending (reset wins)
    step(1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 17; i++) step(1'b1, 1'b1, 8'(8'h80 + i), 1'b0);
    chk("c17_cnt", 32'(count),  32'd17);
    chk("c17_ptr", 32'(wr_ptr), 32'd16);
    step(1'b0, 1'b1, 8'h99, 1'b0);
    chk_reset_state("mid_rst");
    step(1'b1, 1'b1, 8'h3C, 1'b0);
    chk("post_ptr",  32'(wr_ptr),     32'd0);
    chk("post_cnt",  32'(count),      32'd1);
    chk("post_data", 32'(data_in_f),  32'h3C);
    chk("post_wen",  32'(write_en_o), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
